// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder plus a carry flop processes a
// WIDTH-bit operand pair LSB first, one bit per clock, under a start/busy/done
// handshake. Reports carry-out (no-borrow for subtraction) and signed overflow.

// Single-bit full adder; the only arithmetic in the datapath.
module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_out_o,
    output logic             overflow_o
);
    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [WIDTH-1:0] a_d, b_d, sum_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             busy_q, done_q, cout_q, ovf_q;
    logic             fa_s, fa_c;

    serial_adder_fa u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // Next shift-register contents: operands move right, new sum bit enters at the MSB.
    always_comb begin
        logic [WIDTH-1:0] s_vec;
        s_vec            = '0;
        s_vec[WIDTH-1]   = fa_s;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        sum_d            = (sum_q >> 1) | s_vec;
    end

    // Control FSM and datapath registers; every output comes straight from a flop.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    sum_q   <= sum_d;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // On the MSB edge carry_q is the carry into the MSB
                        // (the seed carry when WIDTH=1), so it captures overflow directly.
                        cout_q  <= fa_c;
                        ovf_q   <= carry_q ^ fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sum_o       = sum_q;
    assign carry_out_o = cout_q;
    assign overflow_o  = ovf_q;

endmodule
